// File: rtl/mdu_divider_if.sv
// Handshake bundle between the EX-stage control logic and the sequential divider.
// Requests flow master -> slave; status and results flow back.
interface mdu_divider_if;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_by_zero;

    modport master (
        output start,
        output is_signed,
        output dividend,
        output divisor,
        output flush,
        input  busy,
        input  done,
        input  hi_out,
        input  lo_out,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  is_signed,
        input  dividend,
        input  divisor,
        input  flush,
        output busy,
        output done,
        output hi_out,
        output lo_out,
        output div_by_zero
    );
endinterface

// File: rtl/mdu_divider.sv
// Radix-2 restoring divider for DIV/DIVU: quotient to LO, remainder to HI.
// 32 iteration cycles plus one sign-fixup cycle per operation.
module mdu_divider (
    input  logic          clk,
    input  logic          rst_n,
    mdu_divider_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP
    } state_t;

    state_t      state_q, state_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        a_neg;
    logic        b_neg;
    logic [33:0] diff;

    assign a_neg = bus.is_signed & bus.dividend[31];
    assign b_neg = bus.is_signed & bus.divisor[31];
    assign a_mag = a_neg ? (~bus.dividend + 32'd1) : bus.dividend;
    assign b_mag = b_neg ? (~bus.divisor + 32'd1) : bus.divisor;

    // rem stays below the divisor, so bit 33 of the trial acts as the sign
    assign diff = {rem_q, quo_q[31]} - {2'b00, dvs_q};

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    quo_d   = a_mag;
                    dvs_d   = b_mag;
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                    rem_d   = 33'd0;
                    cnt_d   = 6'd0;
                    state_d = S_CALC;
                end
            end

            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (!diff[33]) begin
                        rem_d = diff[32:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[31:0], quo_q[31]};
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d = S_FIXUP;
                    end
                end
            end

            S_FIXUP: begin
                state_d = S_IDLE;
                if (!bus.flush) begin
                    lo_d   = q_neg_q ? (~quo_q + 32'd1) : quo_q;
                    hi_d   = r_neg_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
                    done_d = 1'b1;
                    dbz_d  = (dvs_q == 32'd0);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= 33'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            cnt_q   <= 6'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.hi_out      = hi_q;
    assign bus.lo_out      = lo_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mdu_divider.sv
// Bench for mdu_divider: vector table, random ops against a magnitude model,
// and hand sequences for ignored start, back-to-back, flush and reset.
module tb_mdu_divider;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mdu_divider_if bus ();

    mdu_divider u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
    } vec_t;

    vec_t        sb[$];
    vec_t        tbl[10];
    int          errors   = 0;
    int          checks   = 0;
    int          done_cnt = 0;
    logic [31:0] last_lo  = '0;
    logic [31:0] last_hi  = '0;
    logic        last_dbz = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t model(logic sgn, logic [31:0] a, logic [31:0] b);
        vec_t        v;
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
        if (mb == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = ma;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        v.sgn = sgn;
        v.a   = a;
        v.b   = b;
        v.lo  = (sgn && (a[31] ^ b[31])) ? -q : q;
        v.hi  = (sgn && a[31]) ? -r : r;
        v.dbz = (b == 32'd0);
        return v;
    endfunction

    always @(negedge clk) begin
        vec_t e;
        if (rst_n && bus.done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: lo %h hi %h", bus.lo_out, bus.hi_out);
            end else begin
                e = sb.pop_front();
                check("lo_out", bus.lo_out, e.lo);
                check("hi_out", bus.hi_out, e.hi);
                check("div_by_zero", {31'b0, bus.div_by_zero}, {31'b0, e.dbz});
                check("busy_with_done", {31'b0, bus.busy}, 32'd0);
            end
        end
    end

    task automatic issue(vec_t v, bit push);
        bus.is_signed = v.sgn;
        bus.dividend  = v.a;
        bus.divisor   = v.b;
        bus.start     = 1'b1;
        if (push) begin
            sb.push_back(v);
            last_lo  = v.lo;
            last_hi  = v.hi;
            last_dbz = v.dbz;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n, output int b);
        n = 0;
        b = 0;
        while (!bus.done && n < 100) begin
            if (bus.busy) b++;
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: waited %0d cycles", n);
        end
    endtask

    task automatic settle_check(string name, int dc);
        repeat (40) @(posedge clk);
        #1;
        check(name, done_cnt, dc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   n;
        int   b;
        int   dc;
        vec_t v;

        tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
        tbl[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
        tbl[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
        tbl[4] = '{1'b0, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  32'hF,          1'b0};
        tbl[5] = '{1'b0, 32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234,       1'b1};
        tbl[6] = '{1'b0, 32'd50,         32'd5,          32'd10,         32'd0,          1'b0};
        tbl[7] = '{1'b1, 32'hFFFF_FF9C,  32'd0,          32'd1,          32'hFFFF_FF9C,  1'b1};
        tbl[8] = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0};
        tbl[9] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0};

        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.flush     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_hi", bus.hi_out, 32'd0);
        check("rst_lo", bus.lo_out, 32'd0);
        check("rst_dbz", {31'b0, bus.div_by_zero}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            issue(tbl[i], 1'b1);
            wait_done(n, b);
            check("latency", n, 33);
            check("busy_cycles", b, 33);
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 6; i++) begin
            v = model(1'($urandom_range(0, 1)), $urandom, (i == 5) ? 32'd0 : ($urandom >> $urandom_range(0, 31)));
            issue(v, 1'b1);
            wait_done(n, b);
            check("rand_latency", n, 33);
            @(posedge clk);
            #1;
        end

        // start mid-operation must not disturb the running divide
        dc = done_cnt;
        issue('{1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0}, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        bus.dividend  = 32'd77;
        bus.divisor   = 32'd3;
        bus.is_signed = 1'b1;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(n, b);
        settle_check("ignored_start_done_count", dc + 1);

        // start accepted in the done cycle
        issue(model(1'b0, 32'd300, 32'd20), 1'b1);
        wait_done(n, b);
        issue(model(1'b1, 32'hFFFF_FF9C, 32'd0), 1'b1);
        wait_done(n, b);
        check("back_to_back_latency", n, 33);
        @(posedge clk);
        #1;

        // flush mid-CALC
        dc = done_cnt;
        issue(model(1'b0, 32'd999, 32'd3), 1'b0);
        repeat (19) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_busy", {31'b0, bus.busy}, 32'd0);
        check("flush_lo_kept", bus.lo_out, last_lo);
        check("flush_hi_kept", bus.hi_out, last_hi);
        check("flush_dbz_kept", {31'b0, bus.div_by_zero}, {31'b0, last_dbz});
        settle_check("flush_no_done", dc);

        // flush in the FIXUP cycle
        issue(model(1'b0, 32'd64, 32'd8), 1'b0);
        repeat (32) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("fixup_flush_done", {31'b0, bus.done}, 32'd0);
        check("fixup_flush_lo_kept", bus.lo_out, last_lo);
        settle_check("fixup_flush_no_done", dc);

        // reset mid-operation
        issue(model(1'b0, 32'd500, 32'd7), 1'b0);
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", {31'b0, bus.busy}, 32'd0);
        check("midrst_done", {31'b0, bus.done}, 32'd0);
        check("midrst_hi", bus.hi_out, 32'd0);
        check("midrst_lo", bus.lo_out, 32'd0);
        check("midrst_dbz", {31'b0, bus.div_by_zero}, 32'd0);
        rst_n = 1'b1;
        settle_check("midrst_no_done", dc);

        issue(tbl[9], 1'b1);
        wait_done(n, b);
        check("recover_latency", n, 33);
        @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
